// File: rtl/tx_disparity_encoder_if.sv
// Interface for the tx disparity encoder.
// It carries the word stream from the tx interface stage to the encoder, and
// the encoded 67-bit word stream from the encoder to the gearbox.
// The master modport drives the words in. The slave modport is the encoder itself.
interface tx_disparity_encoder_if;
  logic        [63:0] DATA_IN;
  logic        [1:0]  HEADER_IN;
  logic               DATA_IN_VALID;
  logic        [66:0] DATA_OUT;
  logic               DATA_OUT_VALID;
  logic               HEADER_ERR;
  logic signed [8:0]  RUNNING_DISP;

  modport master (
    output DATA_IN,
    output HEADER_IN,
    output DATA_IN_VALID,
    input  DATA_OUT,
    input  DATA_OUT_VALID,
    input  HEADER_ERR,
    input  RUNNING_DISP
  );

  modport slave (
    input  DATA_IN,
    input  HEADER_IN,
    input  DATA_IN_VALID,
    output DATA_OUT,
    output DATA_OUT_VALID,
    output HEADER_ERR,
    output RUNNING_DISP
  );
endinterface

// File: rtl/tx_disparity_encoder.sv
// 64b/67b disparity encoder. It is a two-stage pipeline.
// Stage 1 registers the word and its disparity D_w = 2*popcount({H,D}) - 66.
// Stage 2 decides whether to invert the payload. It then emits {inv,H,D'} and
// updates the signed running disparity (RD).
// A word is inverted only when its disparity pushes RD further in the same direction.
// Illegal headers (00/11) are never inverted. They are flagged on HEADER_ERR.
module tx_disparity_encoder #(
  parameter bit INVERT_EN = 1'b1
) (
  input logic              USER_CLK,
  input logic              SYSTEM_RESET,
  tx_disparity_encoder_if.slave bus
);

  logic        [65:0] word_in;
  logic        [6:0]  pop_in;
  logic signed [8:0]  dw_in;

  logic               s1_valid;
  logic        [1:0]  s1_header;
  logic        [63:0] s1_data;
  logic signed [8:0]  s1_dw;

  logic               header_legal;
  logic               same_sign;
  logic               do_invert;
  logic        [66:0] word_out;
  logic signed [8:0]  rd_next;

  logic        [66:0] data_out_q;
  logic               valid_out_q;
  logic               header_err_q;
  logic signed [8:0]  rd;

  assign word_in = {bus.HEADER_IN, bus.DATA_IN};

  // Count the ones in the header plus payload and turn the count into a signed disparity.
  always_comb begin
    pop_in = '0;
    for (int i = 0; i < 66; i++) begin
      pop_in = pop_in + {6'd0, word_in[i]};
    end
    dw_in = $signed({1'b0, pop_in, 1'b0}) - 9'sd66;
  end

  // Stage 1 register: capture the word and its disparity. Reset drops any word in flight.
  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      s1_valid  <= 1'b0;
      s1_header <= '0;
      s1_data   <= '0;
      s1_dw     <= '0;
    end else begin
      s1_valid  <= bus.DATA_IN_VALID;
      s1_header <= bus.HEADER_IN;
      s1_data   <= bus.DATA_IN;
      s1_dw     <= dw_in;
    end
  end

  // Stage 2 decision: invert only a legal word whose nonzero disparity has the same sign as a nonzero RD.
  always_comb begin
    header_legal = (s1_header == 2'b01) || (s1_header == 2'b10);
    same_sign    = (rd != 9'sd0) && (s1_dw != 9'sd0) && (rd[8] == s1_dw[8]);
    do_invert    = INVERT_EN && header_legal && same_sign;
    if (do_invert) begin
      word_out = {1'b1, s1_header, ~s1_data};
      rd_next  = rd - s1_dw + 9'sd1;
    end else begin
      word_out = {1'b0, s1_header, s1_data};
      rd_next  = rd + s1_dw - 9'sd1;
    end
  end

  // Stage 2 register: emit the encoded word and advance RD. Outputs are forced to zero on idle cycles.
  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      header_err_q <= 1'b0;
      rd           <= '0;
    end else if (s1_valid) begin
      data_out_q   <= word_out;
      valid_out_q  <= 1'b1;
      header_err_q <= ~header_legal;
      rd           <= rd_next;
    end else begin
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      header_err_q <= 1'b0;
    end
  end

  assign bus.DATA_OUT       = data_out_q;
  assign bus.DATA_OUT_VALID = valid_out_q;
  assign bus.HEADER_ERR     = header_err_q;
  assign bus.RUNNING_DISP   = rd;

  // The inversion rule keeps RD within +/-68 for legal traffic, so any excursion beyond that is a design error.
  rd_bound_a: assert property (@(posedge USER_CLK) disable iff (SYSTEM_RESET)
    (rd >= -9'sd68) && (rd <= 9'sd68));

endmodule

// File: tb/tb_tx_disparity_encoder.sv
// Scoreboard testbench for tx_disparity_encoder.
// The stimulus tasks push each expected response, including its arrival cycle, into a queue.
// A monitor pops entries and compares them on every valid output.
// On idle cycles the monitor checks that the outputs are zero.
module tb_tx_disparity_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  typedef struct {
    int                cyc;
    logic [66:0]       out;
    logic              err;
    logic signed [8:0] rd;
  } exp_t;

  exp_t              sb[$];
  int                checks   = 0;
  int                failures = 0;
  bit                mon_en   = 1'b0;
  logic signed [8:0] model_rd = '0;

  tx_disparity_encoder_if bus();

  tx_disparity_encoder #(.INVERT_EN(1'b1)) dut (
    .USER_CLK    (clk),
    .SYSTEM_RESET(rst),
    .bus         (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to check the two-cycle latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] h, input logic [63:0] d,
                               input logic [66:0] eo, input logic ee,
                               input logic signed [8:0] er);
    exp_t e;
    @(posedge clk); #1;
    bus.HEADER_IN     = h;
    bus.DATA_IN       = d;
    bus.DATA_IN_VALID = 1'b1;
    e.cyc = cyc + 2;
    e.out = eo;
    e.err = ee;
    e.rd  = er;
    sb.push_back(e);
    model_rd = er;
  endtask

  task automatic applyIdle();
    @(posedge clk); #1;
    bus.DATA_IN_VALID = 1'b0;
    bus.DATA_IN       = '0;
    bus.HEADER_IN     = '0;
  endtask

  // Random legal word, with its expected response derived from the running model RD
  task automatic applyRandom();
    logic [1:0]  h;
    logic [63:0] d;
    logic [66:0] eo;
    int          dw;
    int          r;
    int          nr;
    h  = 2'($urandom_range(1, 2));
    d  = {$urandom, $urandom};
    dw = 2 * $countones({h, d}) - 66;
    r  = int'(model_rd);
    if (r != 0 && dw != 0 && ((r > 0) == (dw > 0))) begin
      eo = {1'b1, h, ~d};
      nr = r - dw + 1;
    end else begin
      eo = {1'b0, h, d};
      nr = r + dw - 1;
    end
    applyStimulus(h, d, eo, 1'b0, 9'(nr));
  endtask

  task automatic drain();
    int budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput("drain_pending", 67'(sb.size()), 67'd0);
    sb.delete();
  endtask

  // Monitor: compare each valid output against the scoreboard, and require zeros when idle
  always @(negedge clk) begin
    exp_t e;
    int   r;
    if (mon_en) begin
      if (bus.DATA_OUT_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 67'd1, 67'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency_cycle", 67'(cyc), 67'(e.cyc));
          checkOutput("data_out", bus.DATA_OUT, e.out);
          checkOutput("header_err", 67'(bus.HEADER_ERR), 67'(e.err));
          checkOutput("running_disp", 67'(bus.RUNNING_DISP), 67'(e.rd));
          r = int'(bus.RUNNING_DISP);
          checkOutput("rd_bound", 67'((r <= 68 && r >= -68) ? 1 : 0), 67'd1);
        end
      end else begin
        checkOutput("idle_data_out", bus.DATA_OUT, 67'd0);
        checkOutput("idle_header_err", 67'(bus.HEADER_ERR), 67'd0);
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence
  initial begin
    bus.DATA_IN       = '0;
    bus.HEADER_IN     = '0;
    bus.DATA_IN_VALID = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data_out", bus.DATA_OUT, 67'd0);
    checkOutput("reset_valid", 67'(bus.DATA_OUT_VALID), 67'd0);
    checkOutput("reset_header_err", 67'(bus.HEADER_ERR), 67'd0);
    checkOutput("reset_rd", 67'(bus.RUNNING_DISP), 67'd0);
    bus.DATA_IN_VALID = 1'b0;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed batch 1: inversion on both signs, zero-disparity word, opposite-sign pass-through
    applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 67'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, 9'sd63);
    applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 67'h5_0000_0000_0000_0000, 1'b0, 9'sd0);
    applyStimulus(2'b10, 64'h0000_0000_FFFF_FFFF, 67'h2_0000_0000_FFFF_FFFF, 1'b0, -9'sd1);
    applyStimulus(2'b10, 64'h0000_0000_0000_0000, 67'h6_FFFF_FFFF_FFFF_FFFF, 1'b0, 9'sd64);
    applyStimulus(2'b10, 64'h0000_0000_0000_0000, 67'h2_0000_0000_0000_0000, 1'b0, -9'sd1);
    applyIdle();
    drain();

    // Reset pulse with an idle pipeline
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rd = '0;
    @(negedge clk);
    checkOutput("reset2_rd", 67'(bus.RUNNING_DISP), 67'd0);

    // Directed batch 2: illegal headers, and inversion from a negative RD
    applyStimulus(2'b00, 64'h0000_0000_0000_0000, 67'h0_0000_0000_0000_0000, 1'b1, -9'sd67);
    applyStimulus(2'b01, 64'h0000_0000_0000_0000, 67'h5_FFFF_FFFF_FFFF_FFFF, 1'b0, -9'sd2);
    applyStimulus(2'b11, 64'h0000_0000_0000_0000, 67'h3_0000_0000_0000_0000, 1'b1, -9'sd65);
    applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 67'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, -9'sd2);
    applyIdle();
    drain();

    // Mid-stream reset: word A is in stage 1 and word B is at the input when reset hits.
    // Neither word may ever appear at the output.
    @(posedge clk); #1;
    bus.HEADER_IN     = 2'b01;
    bus.DATA_IN       = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.DATA_IN_VALID = 1'b1;
    @(posedge clk); #1;
    bus.HEADER_IN     = 2'b10;
    bus.DATA_IN       = 64'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.DATA_IN_VALID = 1'b0;
    model_rd = '0;
    @(negedge clk);
    checkOutput("midreset_rd", 67'(bus.RUNNING_DISP), 67'd0);
    checkOutput("midreset_valid", 67'(bus.DATA_OUT_VALID), 67'd0);
    repeat (3) @(posedge clk);

    // Resume: first word after reset, then 100 back-to-back random legal words
    applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 67'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, 9'sd63);
    for (int i = 0; i < 100; i++) applyRandom();
    applyIdle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_disparity_encoder.md
TX_DISPARITY_ENCODER -- requirements
Module: tx_disparity_encoder

Interface
REQ-001 SHALL expose parameter INVERT_EN, default 1; 1 enables 64b/67b disparity inversion, 0 forces pass-through with inversion bit 0.
REQ-002 SHALL have port USER_CLK, input, 1, the single clock for all logic.
REQ-003 SHALL have port SYSTEM_RESET, input, 1, synchronous active-high reset sampled on USER_CLK rising edge.
REQ-004 SHALL have port DATA_IN, input, 64, payload or control word from the tx interface stage.
REQ-005 SHALL have port HEADER_IN, input, 2, framing header: 01 data, 10 control.
REQ-006 SHALL have port DATA_IN_VALID, input, 1, qualifies DATA_IN/HEADER_IN; driven by the upstream DATA_VALID.
REQ-007 SHALL have port DATA_OUT, output, 67, {inversion bit[66], header[65:64], data[63:0]} to the gearbox.
REQ-008 SHALL have port DATA_OUT_VALID, output, 1, qualifies DATA_OUT.
REQ-009 SHALL have port HEADER_ERR, output, 1, one-cycle pulse aligned with DATA_OUT_VALID when the header was 00 or 11.
REQ-010 SHALL have port RUNNING_DISP, output, 9, signed two's-complement running disparity after the last emitted word.

Function
REQ-011 SHALL be a 2-stage pipeline: stage 1 registers header, data, valid and D_w; stage 2 decides inversion, registers outputs and updates RD.
REQ-012 SHALL compute D_w = 2*popcount({HEADER_IN,DATA_IN}) - 66, signed, range -66..+66.
REQ-013 SHALL assert DATA_OUT_VALID exactly 2 cycles after a sampled DATA_IN_VALID, aligned with the upstream GEARBOX_VALID.
REQ-014 SHALL accept DATA_IN_VALID on every cycle, including back-to-back, with no stall or ready signal.
REQ-015 SHALL invert when INVERT_EN=1, header legal, RD!=0, D_w!=0 and sign(D_w)==sign(RD); otherwise it shall not invert.
REQ-016 Non-inverted word: DATA_OUT={1'b0,H,D}; RD_next = RD + D_w - 1.
REQ-017 Inverted word: DATA_OUT={1'b1,H,~D}, header never inverted; RD_next = RD - D_w + 1.
REQ-018 SHALL treat headers 00/11 as illegal: pass through uninverted, RD updated per REQ-016, HEADER_ERR pulsed.
REQ-019 SHALL hold RD unchanged on cycles with no valid word in stage 2.
REQ-020 SHALL drive DATA_OUT to all zeros and HEADER_ERR low on every cycle where DATA_OUT_VALID is low.
REQ-021 RD SHALL never exceed the 9-bit signed range; |RD|<=68 is guaranteed by REQ-015 and SHALL be asserted in simulation.

Reset
REQ-022 When SYSTEM_RESET is high at a clock edge, DATA_OUT=0, DATA_OUT_VALID=0, HEADER_ERR=0, RD=0 and all pipeline valids shall clear on that edge.
REQ-023 Words in flight when reset is asserted SHALL be discarded; valid input sampled during reset is ignored.
REQ-024 The first valid word after reset release SHALL appear at DATA_OUT 2 cycles after it is sampled.

Verification
REQ-025 Reset; H=01, D=FFFF_FFFF_FFFF_FFFF valid at cycle n -> cycle n+2 DATA_OUT=67'h1_FFFF_FFFF_FFFF_FFFF, valid=1, RUNNING_DISP=63.
REQ-026 Same word again at n+1 -> n+3 DATA_OUT=67'h5_0000_0000_0000_0000 (inverted), RUNNING_DISP=0.
REQ-027 From RD=0: H=10, D=0000_0000_FFFF_FFFF -> D_w=0, no inversion, DATA_OUT=67'h2_0000_0000_FFFF_FFFF, RUNNING_DISP=-1.
REQ-028 H=00, D=0 from RD=0 -> HEADER_ERR=1 for one cycle at n+2, DATA_OUT=0, no inversion, RUNNING_DISP=-67.
REQ-029 100 back-to-back random legal words -> one output per cycle, 2-cycle latency; a reference model tracks RD exactly; |RD|<=68 throughout.
REQ-030 SYSTEM_RESET pulsed for 1 cycle mid-stream with 2 words in flight -> those words never appear, outputs and RD read 0 next cycle, then normal operation resumes.
